// File: rtl/crc_stream_if.sv
// Handshake bundle between a beat producer / result consumer and crc_stream.
// master: the side driving message beats and taking results.
// slave:  the CRC engine.
interface crc_stream_if #(
  parameter int CRC_W  = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              crc_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  crc;
  logic              crc_ok;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, crc_valid, crc, crc_ok
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, crc_valid, crc, crc_ok
  );
endinterface

// File: rtl/crc_stream.sv
// Handshaked, framed CRC engine. Folds DATA_W message bits per accepted beat
// into a CRC_W-bit remainder (direct, non-augmented form) and presents a
// registered result with backpressure and a residue-clean flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a first beat; non-first beats are dropped
// S_ACCUM | inside a frame, folding beats into the remainder
// S_HOLD  | result on crc/crc_ok, waiting for the consumer
module crc_stream #(
  parameter int               CRC_W   = 8,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(7),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
  input logic          clk_i,
  input logic          rst_n_i,
  input logic          clear_i,
  crc_stream_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] rem_q, rem_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic             ok_q, ok_d;

  logic             accept;
  logic             load;
  logic [CRC_W-1:0] rem_base;
  logic [CRC_W-1:0] rem_new;

  // One whole beat of the bit-serial division, MSB of the data first.
  function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] rem_in,
                                            input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = rem_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ data[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  // Handshake and remainder datapath. A first beat always restarts from INIT,
  // even in the middle of a frame.
  always_comb begin
    bus.in_ready  = (state_q == S_HOLD) ? bus.out_ready : 1'b1;
    bus.crc_valid = (state_q == S_HOLD);
    bus.crc       = crc_q;
    bus.crc_ok    = ok_q;
    accept        = bus.in_valid & bus.in_ready;
    // In HOLD an accepted beat implies out_ready, so only first beats start work
    load          = (state_q == S_ACCUM) ? accept : (accept & bus.in_first);
    rem_base      = ((state_q == S_ACCUM) && !bus.in_first) ? rem_q : INIT;
    rem_new       = step(rem_base, bus.in_data);
  end

  // Next-state logic; the result registers only change on entry to HOLD.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    if (clear_i) begin
      state_d = S_IDLE;
      rem_d   = INIT;
    end else begin
      if ((state_q == S_HOLD) && bus.out_ready) state_d = S_IDLE;
      if (load) begin
        rem_d = rem_new;
        if (bus.in_last) begin
          state_d = S_HOLD;
          crc_d   = rem_new ^ XOR_OUT;
          ok_d    = (rem_new == '0);
        end else begin
          state_d = S_ACCUM;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      rem_q   <= INIT;
      crc_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      ok_q    <= ok_d;
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: fixed vector table, hand-written multi-cycle sequences,
// a bit-serial (DATA_W = 1) instance and randomized frames checked against a
// polynomial long-division reference model.
module tb_crc_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr1 = 1'b0;

  always #5 clk = ~clk;

  crc_stream_if #(.CRC_W(8), .DATA_W(8)) bus ();
  crc_stream_if #(.CRC_W(8), .DATA_W(1)) bus1 ();

  crc_stream #(.CRC_W(8), .DATA_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clr), .bus(bus.slave));

  crc_stream #(.CRC_W(8), .DATA_W(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .clear_i(clr1), .bus(bus1.slave));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic       ev;
    logic [7:0] ec;
    logic       eo;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  msg9[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0]  exp_q[$];
  bit          drv_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as the remainder of M(x) * x^8 divided by x^8 + x^2 + x + 1,
  // done as textbook long division over an explicit bit list.
  function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
    bit          b[$];
    logic [8:0]  g;
    logic [7:0]  r;
    g = 9'h107;
    foreach (m[k]) for (int j = 7; j >= 0; j--) b.push_back(m[k][j]);
    for (int j = 0; j < 8; j++) b.push_back(1'b0);
    for (int i = 0; i < b.size() - 8; i++)
      if (b[i]) for (int j = 0; j <= 8; j++) b[i+j] = b[i+j] ^ g[8-j];
    for (int j = 0; j < 8; j++) r[7-j] = b[b.size()-8+j];
    return r;
  endfunction

  task automatic add(input logic [7:0] d, input logic f, input logic l,
                     input logic ev, input logic [7:0] ec, input logic eo);
    vec_t v;
    v.d = d; v.f = f; v.l = l; v.ev = ev; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endtask

  // Presents a beat from posedge+1 and returns at posedge+1 after it is taken.
  task automatic send_beat(input logic [7:0] d, input logic f, input logic l);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_first = f;
    bus.in_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL beat_timeout: got stalled expected accept");
        n_err++;
        n_vec++;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_check(input string name);
    for (int i = 0; i < 9; i++) send_beat(msg9[i], i == 0, i == 8);
    chk({name, "_valid"}, 32'(bus.crc_valid), 32'd1);
    chk({name, "_crc"}, 32'(bus.crc), 32'hF4);
    chk({name, "_ok"}, 32'(bus.crc_ok), 32'd0);
  endtask

  initial begin
    logic [71:0] bits;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_first = 1'b0; bus1.in_last = 1'b0;
    bus1.out_ready = 1'b1;

    #3;
    chk("rst_valid", 32'(bus.crc_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_crc", 32'(bus.crc), 32'd0);
    chk("rst_ok", 32'(bus.crc_ok), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven beats, out_ready held high ----------------
    for (int i = 0; i < 9; i++) add(msg9[i], i == 0, i == 8, i == 8, 8'hF4, 1'b0);
    add(8'h00, 1, 1, 1, 8'h00, 1'b1);
    add(8'h01, 1, 1, 1, 8'h07, 1'b0);
    add(8'hAA, 0, 0, 0, 8'h00, 1'b0);
    add(8'h55, 0, 0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) add(msg9[i], i == 0, 1'b0, 1'b0, 8'h00, 1'b0);
    add(8'hF4, 0, 1, 1, 8'h00, 1'b1);
    foreach (tbl[i]) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tbl[i].d;
      bus.in_first = tbl[i].f;
      bus.in_last  = tbl[i].l;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.crc_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_crc", i), 32'(bus.crc), 32'(tbl[i].ec));
        chk($sformatf("tbl%0d_ok", i), 32'(bus.crc_ok), 32'(tbl[i].eo));
      end
    end
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    @(posedge clk); #1;
    chk("tbl_pulse_end", 32'(bus.crc_valid), 32'd0);

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    send_check("bp_first");
    chk("bp_ready0", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'h31; bus.in_first = 1'b1; bus.in_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.crc_valid), 32'd1);
      chk("bp_stall_crc", 32'(bus.crc), 32'hF4);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_passthru", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0;
    chk("bp_consumed", 32'(bus.crc_valid), 32'd0);
    for (int i = 1; i < 9; i++) send_beat(msg9[i], 1'b0, i == 8);
    chk("bp_second_valid", 32'(bus.crc_valid), 32'd1);
    chk("bp_second_crc", 32'(bus.crc), 32'hF4);
    @(posedge clk); #1;

    // ---------------- clear during HOLD ----------------
    bus.out_ready = 1'b0;
    send_check("clr_pre");
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", 32'(bus.crc_valid), 32'd0);
    bus.out_ready = 1'b1;
    send_check("clr_post");
    @(posedge clk); #1;

    // ---------------- in_first mid-frame restarts ----------------
    send_beat(8'hAA, 1'b1, 1'b0);
    send_beat(8'hBB, 1'b0, 1'b0);
    send_check("restart");
    @(posedge clk); #1;

    // ---------------- reset mid-frame (result regs hold F4 beforehand) -------
    for (int i = 0; i < 4; i++) send_beat(msg9[i], i == 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.crc_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_crc", 32'(bus.crc), 32'd0);
    chk("arst_ok", 32'(bus.crc_ok), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_check("arst_post");
    @(posedge clk); #1;

    // ---------------- bit-serial instance ----------------
    for (int i = 0; i < 9; i++) bits[71-8*i -: 8] = msg9[i];
    for (int i = 0; i < 72; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = bits[71-i];
      bus1.in_first = (i == 0);
      bus1.in_last  = (i == 71);
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    chk("w1_valid", 32'(bus1.crc_valid), 32'd1);
    chk("w1_crc", 32'(bus1.crc), 32'hF4);
    chk("w1_ok", 32'(bus1.crc_ok), 32'd0);

    // ---------------- randomized frames vs. reference model ----------------
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0] m[$];
          int len;
          len = $urandom_range(1, 6);
          m = {};
          for (int k = 0; k < len; k++) m.push_back(8'($urandom_range(0, 255)));
          if (f % 7 == 3) begin
            m.push_back(ref_crc(m));
            len++;
          end
          exp_q.push_back(ref_crc(m));
          for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #0;
            send_beat(m[k], k == 0, k == len - 1);
          end
        end
        drv_done = 1'b1;
      end
      begin
        int cyc;
        logic [7:0] e;
        cyc = 0;
        while (!(drv_done && exp_q.size() == 0) && cyc < 5000) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
          #1;
          if (bus.crc_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              chk("rand_unexpected", 32'(bus.crc_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("rand_crc", 32'(bus.crc), 32'(e));
              chk("rand_ok", 32'(bus.crc_ok), 32'(e == 8'h00));
            end
          end
          cyc++;
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
      end
    join
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_stream.md
# crc_stream

Parametrised, handshaked CRC engine for the controller/pak data path. It folds DATA_W message bits per cycle into a CRC_W-bit remainder using the direct (non-augmented) algorithm, so no trailing zero padding is required. It frames messages with first/last flags and presents a registered result with backpressure and a residue-check flag. It replaces the fixed 8-bit, 1-bit-per-clock serial generator wherever byte-wide or configurable CRCs are needed.

## Interface
- CRC_W, 8, remainder width (>= 2)
- DATA_W, 8, message bits consumed per accepted beat (>= 1)
- POLY, 8'h07, generator polynomial without the implicit x^CRC_W term
- INIT, 0, remainder value loaded at frame start
- XOR_OUT, 0, value XORed into the remainder to form `crc`
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort: highest priority after reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted on this edge when in_valid & in_ready
- in_data  in  DATA_W  message bits, MSB first in time
- in_first  in  1  beat starts a frame
- in_last  in  1  beat ends a frame
- crc_valid  out  1  result held on crc/crc_ok
- out_ready  in  1  consumer takes result when crc_valid & out_ready
- crc  out  CRC_W  rem ^ XOR_OUT of the completed frame
- crc_ok  out  1  1 when raw remainder == 0 (frame with its appended CRC checks clean, XOR_OUT = 0)

## Operation
- Bit step, applied DATA_W times per beat, MSB of in_data first: fb = rem[CRC_W-1] ^ d; rem = rem << 1 (truncated to CRC_W); if fb, rem ^= POLY. Fully unrolled; one beat per cycle.
- State machine has three states:
  - IDLE: in_ready = 1. An accepted beat with in_first sets rem = step(INIT, in_data). It then goes to HOLD if in_last is also set, otherwise to ACCUM. An accepted beat without in_first is discarded and the state stays IDLE.
  - ACCUM: in_ready = 1. An accepted beat sets rem = step(rem, in_data). If that beat has in_first, the frame restarts with rem = step(INIT, in_data). If in_last is set, the state goes to HOLD.
  - HOLD: crc_valid = 1, and crc/crc_ok are stable. in_ready = out_ready, a combinational pass-through. On out_ready the state leaves HOLD. If a beat is accepted on the same edge, it is processed as in IDLE (first beat: to ACCUM or HOLD; non-first beat: discarded, to IDLE). If no beat is accepted, the state goes to IDLE.
- crc and crc_ok are registered when entering HOLD. They keep their last value outside HOLD. Consumers qualify them with crc_valid only.
- clear = 1 puts the state in IDLE and sets rem = INIT and crc_valid = 0. Any pending result is dropped, and a beat presented that cycle is not processed. in_ready is still driven as for the current state.
- Reset values: state IDLE, rem = INIT, crc = 0, crc_ok = 0, crc_valid = 0, in_ready = 1.
- Reset asserted mid-frame or during HOLD discards everything. There is no partial-result output.

## Timing
- Result latency is 1 cycle. If the last beat is accepted at edge k, crc_valid is high after edge k, and the first possible consumer handshake is edge k+1.
- Sustained throughput is one beat per cycle with out_ready held high. Back-to-back frames need no idle cycle because the HOLD exit and the next in_first beat share an edge.
- With out_ready low in HOLD, in_ready is 0 and crc_valid, crc and crc_ok are held indefinitely.
- The only combinational input-to-output path is out_ready -> in_ready.

## Test plan
- Defaults, beats 0x31..0x39 (first on 0x31, last on 0x39), out_ready = 1 -> crc_valid pulses for 1 cycle after the 0x39 edge with crc = 0xF4, crc_ok = 0.
- Same frame with 0xF4 appended as the 10th beat (last) -> crc = 0x00, crc_ok = 1.
- Single-beat frames (first & last): 0x00 -> crc 0x00, crc_ok 1. 0x01 -> crc 0x07, crc_ok 0. Also run back-to-back with no gap -> two consecutive crc_valid cycles.
- Backpressure: hold out_ready = 0 after "123456789" -> crc stays 0xF4, in_ready = 0, the next frame's first beat is stalled. Raise out_ready -> result consumed and the stalled beat accepted on the same edge; the second frame also yields 0xF4.
- DATA_W = 1 instance, 72 bits of "123456789" MSB first -> crc = 0xF4, matching the byte-wide instance.
- Abort cases, each followed by a full "123456789" frame that must give 0xF4:
  - pull reset low after 4 beats -> all outputs at reset values;
  - pulse clear during HOLD -> crc_valid drops next cycle;
  - issue in_first mid-frame -> frame restarts.
- Beats without in_first while in IDLE (0xAA, 0x55) are discarded with no crc_valid.
